slot_machine: RTL and testbench



---
 rtl/slot_machine_if.sv | 34 +++
 rtl/slot_machine.sv | 230 +++++++++++++++++++++++
 tb/tb_slot_machine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/slot_machine_if.sv
// ============================================================================
// Module      : slot_machine_if
// Description : Board-pin bundle for the two-reel slot machine (button in,
//               segment/LED/buzzer out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface slot_machine_if;
    logic       PSW;
    logic [7:0] SEG_0;
    logic [7:0] SEG_1;
    logic       BZ;
    logic [7:0] LED;

    modport master (
        output PSW,
        input  SEG_0,
        input  SEG_1,
        input  BZ,
        input  LED
    );

    modport slave (
        input  PSW,
        output SEG_0,
        output SEG_1,
        output BZ,
        output LED
    );
endinterface

`default_nettype wire

// File: rtl/slot_machine.sv
// ============================================================================
// Module      : slot_machine
// Description : Two-reel 0-9 slot machine; one debounced button stops the reels
//               in turn and registers a win. Buzzer built when SLOT_BUZZER_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module slot_machine #(
    parameter int SPIN_DIV = 4,
    parameter int DEB_DIV  = 1,
    parameter int BZ_DIV   = 8
) (
    input wire            CK,
    input wire            RB,
    slot_machine_if.slave bus
);

    localparam int c_SPIN_W = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
    localparam int c_DEB_W  = (DEB_DIV  > 1) ? $clog2(DEB_DIV)  : 1;

    localparam logic [c_SPIN_W-1:0] c_SPIN_LAST = c_SPIN_W'(SPIN_DIV - 1);
    localparam logic [c_SPIN_W-1:0] c_SPIN_ONE  = c_SPIN_W'(1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_DIV - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);
    localparam logic [2:0]          c_FILL_DONE = 3'd4;

    localparam logic [1:0] c_ST_SPIN   = 2'd0;
    localparam logic [1:0] c_ST_LSTOP  = 2'd1;
    localparam logic [1:0] c_ST_RESULT = 2'd2;

    generate
        if (SPIN_DIV < 1 || DEB_DIV < 1 || BZ_DIV < 1) begin : g_param_check
            $error("slot_machine: SPIN_DIV, DEB_DIV and BZ_DIV must be >= 1");
        end
    endgenerate

    function automatic logic [7:0] f_seg(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'hC0;
            4'd1:    p = 8'hF9;
            4'd2:    p = 8'hA4;
            4'd3:    p = 8'hB0;
            4'd4:    p = 8'h99;
            4'd5:    p = 8'h92;
            4'd6:    p = 8'h82;
            4'd7:    p = 8'hF8;
            4'd8:    p = 8'h80;
            4'd9:    p = 8'h90;
            default: p = 8'hFF;
        endcase
        return p;
    endfunction

    logic [c_SPIN_W-1:0] r_spin_cnt;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [1:0]          r_sync;
    logic [1:0]          r_samp;
    logic [2:0]          r_fill;
    logic                r_deb;
    logic                r_press;
    logic [1:0]          r_state;
    logic [3:0]          r_left;
    logic [3:0]          r_right;
    logic                r_win;
    logic [7:0]          r_seg_0;
    logic [7:0]          r_seg_1;
    logic [7:0]          r_led;

    logic                w_spin_tick;
    logic                w_deb_tick;
    logic                w_armed;
    logic                w_deb_next;
    logic [1:0]          w_state_next;
    logic                w_win_next;
    logic                w_left_step;
    logic                w_right_step;
    logic [7:0]          w_led_next;

    assign w_spin_tick = (r_spin_cnt == c_SPIN_LAST);
    assign w_deb_tick  = (r_deb_cnt  == c_DEB_LAST);
    // The chain resets to 0 (= pressed); hold the debounced level until the
    // synchronizer and both samples carry real button values.
    assign w_armed     = (r_fill == c_FILL_DONE);

    always_comb begin
        w_deb_next = r_deb;
        if (w_armed) begin
            if (r_samp == 2'b00) begin
                w_deb_next = 1'b0;
            end else if (r_samp == 2'b11) begin
                w_deb_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_spin_cnt <= '0;
            r_deb_cnt  <= '0;
            r_sync     <= 2'b00;
            r_samp     <= 2'b00;
            r_fill     <= 3'd0;
            r_deb      <= 1'b1;
            r_press    <= 1'b0;
        end else begin
            r_spin_cnt <= w_spin_tick ? '0 : r_spin_cnt + c_SPIN_ONE;
            r_deb_cnt  <= w_deb_tick  ? '0 : r_deb_cnt + c_DEB_ONE;
            r_sync     <= {r_sync[0], bus.PSW};
            if (w_deb_tick) begin
                r_samp <= {r_samp[0], r_sync[1]};
                if (!w_armed) begin
                    r_fill <= r_fill + 3'd1;
                end
            end
            r_deb   <= w_deb_next;
            r_press <= r_deb & ~w_deb_next;
        end
    end

    // State register
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_state <= c_ST_SPIN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_win_next   = r_win;
        case (r_state)
            c_ST_SPIN: begin
                if (r_press) begin
                    w_state_next = c_ST_LSTOP;
                end
            end
            c_ST_LSTOP: begin
                if (r_press) begin
                    w_state_next = c_ST_RESULT;
                    w_win_next   = (r_left == r_right);
                end
            end
            c_ST_RESULT: begin
                if (r_press) begin
                    w_state_next = c_ST_SPIN;
                    w_win_next   = 1'b0;
                end
            end
            default: begin
                w_state_next = c_ST_SPIN;
                w_win_next   = 1'b0;
            end
        endcase
    end

    // Output logic: a reel being stopped by this press skips a coincident tick
    always_comb begin
        w_left_step  = w_spin_tick && (r_state == c_ST_SPIN) && !r_press;
        w_right_step = w_spin_tick && ((r_state == c_ST_SPIN) ||
                                       ((r_state == c_ST_LSTOP) && !r_press));
        w_led_next   = {~w_win_next, 4'b1111,
                        ~(w_state_next == c_ST_RESULT),
                        ~(w_state_next == c_ST_LSTOP),
                        ~(w_state_next == c_ST_SPIN)};
    end

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_left  <= 4'd0;
            r_right <= 4'd0;
            r_win   <= 1'b0;
            r_seg_0 <= 8'hC0;
            r_seg_1 <= 8'hC0;
            r_led   <= 8'hFE;
        end else begin
            if (w_left_step) begin
                r_left <= (r_left == 4'd9) ? 4'd0 : r_left + 4'd1;
            end
            if (w_right_step) begin
                r_right <= (r_right == 4'd0) ? 4'd9 : r_right - 4'd1;
            end
            r_win   <= w_win_next;
            r_seg_0 <= f_seg(r_right);
            r_seg_1 <= f_seg(r_left);
            r_led   <= w_led_next;
        end
    end

    assign bus.SEG_0 = r_seg_0;
    assign bus.SEG_1 = r_seg_1;
    assign bus.LED   = r_led;

`ifdef SLOT_BUZZER_EN
    localparam int c_BZ_W = (BZ_DIV > 1) ? $clog2(BZ_DIV) : 1;
    localparam logic [c_BZ_W-1:0] c_BZ_LAST = c_BZ_W'(BZ_DIV - 1);
    localparam logic [c_BZ_W-1:0] c_BZ_ONE  = c_BZ_W'(1);

    logic [c_BZ_W-1:0] r_bz_cnt;
    logic              r_bz;

    // Counter restarts on every win entry so the tone always begins low
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_bz_cnt <= '0;
            r_bz     <= 1'b0;
        end else if (!w_win_next || !r_win) begin
            r_bz_cnt <= '0;
            r_bz     <= 1'b0;
        end else if (r_bz_cnt == c_BZ_LAST) begin
            r_bz_cnt <= '0;
            r_bz     <= ~r_bz;
        end else begin
            r_bz_cnt <= r_bz_cnt + c_BZ_ONE;
        end
    end

    assign bus.BZ = r_bz;
`else
    assign bus.BZ = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slot_machine.sv
// ============================================================================
// Module      : tb_slot_machine
// Description : Scoreboard bench for slot_machine with directed button presses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_slot_machine;

    localparam int c_B = 3;  // edge index at which reset is released

    localparam int c_SEL_SEG0 = 0;
    localparam int c_SEL_SEG1 = 1;
    localparam int c_SEL_LED  = 2;
    localparam int c_SEL_BZ   = 3;

    logic CK = 1'b0;
    logic RB;
    int   edges = 0;

    slot_machine_if bus();

    slot_machine #(
        .SPIN_DIV (4),
        .DEB_DIV  (1),
        .BZ_DIV   (8)
    ) dut (
        .CK  (CK),
        .RB  (RB),
        .bus (bus)
    );

    always #5 CK = ~CK;
    always @(posedge CK) edges <= edges + 1;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic expect_at(input int k, input int sel, input logic [7:0] v, input string name);
        exp_t e;
        e.cyc  = c_B + k;
        e.sel  = sel;
        e.val  = v;
        e.name = name;
        q.push_back(e);
    endtask

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            c_SEL_SEG0: return bus.SEG_0;
            c_SEL_SEG1: return bus.SEG_1;
            c_SEL_LED:  return bus.LED;
            default:    return {7'b0, bus.BZ};
        endcase
    endfunction

    // Monitor: compare every expectation due after the most recent edge
    always @(negedge CK) begin : mon
        logic [7:0] got;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == edges) begin
                got = pick(q[i].sel);
                n_total++;
                if (got === q[i].val) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s at k=%0d: got %h expected %h",
                             q[i].name, q[i].cyc - c_B, got, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic at(input int k);
        while (edges < c_B + k) begin
            @(posedge CK);
            #2;
        end
    endtask

    task automatic press(input int k0, input int len);
        at(k0);
        bus.PSW = 1'b0;
        at(k0 + len);
        bus.PSW = 1'b1;
    endtask

    initial begin
        RB      = 1'b1;
        bus.PSW = 1'b1;
        #1 RB   = 1'b0;
        #1;

        n_total++;
        if (bus.LED === 8'hFE) n_pass++;
        else $display("FAIL async_reset_led: got %h expected fe", bus.LED);
        n_total++;
        if (bus.SEG_0 === 8'hC0) n_pass++;
        else $display("FAIL async_reset_seg0: got %h expected c0", bus.SEG_0);
        n_total++;
        if (bus.SEG_1 === 8'hC0) n_pass++;
        else $display("FAIL async_reset_seg1: got %h expected c0", bus.SEG_1);
        n_total++;
        if (bus.BZ === 1'b0) n_pass++;
        else $display("FAIL async_reset_bz: got %b expected 0", bus.BZ);

        expect_at(-1, c_SEL_LED,  8'hFE, "led_in_reset");
        expect_at(0,  c_SEL_SEG0, 8'hC0, "reset_seg0");
        expect_at(0,  c_SEL_SEG1, 8'hC0, "reset_seg1");
        expect_at(0,  c_SEL_LED,  8'hFE, "reset_led");
        expect_at(0,  c_SEL_BZ,   8'h00, "reset_bz");
        repeat (3) @(posedge CK);
        #2 RB = 1'b1;

        // Both reels spin: L counts up, R counts down, one step per 4 cycles
        expect_at(4, c_SEL_SEG1, 8'hC0, "spin_l0_hold");
        expect_at(5, c_SEL_SEG1, 8'hF9, "spin_l1");
        expect_at(5, c_SEL_SEG0, 8'h90, "spin_r9");
        expect_at(9, c_SEL_SEG1, 8'hA4, "spin_l2");
        expect_at(9, c_SEL_SEG0, 8'h80, "spin_r8");

        // Stop left at L=3
        expect_at(13, c_SEL_LED,  8'hFE, "stopl_before");
        expect_at(14, c_SEL_LED,  8'hFD, "stopl_led");
        expect_at(17, c_SEL_SEG0, 8'h82, "lstop_r6");
        expect_at(18, c_SEL_SEG1, 8'hB0, "lstop_l_frozen");
        expect_at(21, c_SEL_SEG0, 8'h92, "lstop_r5");
        press(8, 3);

        // Second press while R=3 -> win
        expect_at(29, c_SEL_LED,  8'hFD, "win_before");
        expect_at(29, c_SEL_SEG0, 8'hB0, "win_r3");
        expect_at(30, c_SEL_LED,  8'h7B, "win_led");
        expect_at(35, c_SEL_SEG0, 8'hB0, "win_r_frozen");
        expect_at(35, c_SEL_SEG1, 8'hB0, "win_l_frozen");
        expect_at(40, c_SEL_SEG0, 8'hB0, "win_r_frozen2");
`ifdef SLOT_BUZZER_EN
        expect_at(37, c_SEL_BZ, 8'h00, "bz_low");
        expect_at(38, c_SEL_BZ, 8'h01, "bz_rise");
        expect_at(45, c_SEL_BZ, 8'h01, "bz_high");
        expect_at(46, c_SEL_BZ, 8'h00, "bz_fall");
`else
        expect_at(38, c_SEL_BZ, 8'h00, "bz_tied_a");
        expect_at(46, c_SEL_BZ, 8'h00, "bz_tied_b");
`endif
        press(24, 3);

        // Restart: win clears, reels resume from 3/3
        expect_at(49, c_SEL_LED,  8'h7B, "restart_before");
        expect_at(50, c_SEL_LED,  8'hFE, "restart_led");
        expect_at(50, c_SEL_BZ,   8'h00, "restart_bz");
        expect_at(52, c_SEL_SEG1, 8'hB0, "resume_l_hold");
        expect_at(53, c_SEL_SEG1, 8'h99, "resume_l4");
        expect_at(53, c_SEL_SEG0, 8'hA4, "resume_r2");
        press(44, 3);

        // One-cycle glitch is ignored
        expect_at(60, c_SEL_LED, 8'hFE, "glitch_ignored");
        press(52, 1);

        // Stop left at L=7
        expect_at(65, c_SEL_LED,  8'hFE, "stopl2_before");
        expect_at(66, c_SEL_LED,  8'hFD, "stopl2_led");
        expect_at(67, c_SEL_SEG1, 8'hF8, "stopl2_l7");
        press(60, 3);

        // Long hold: lose with L=7, R=6, exactly one transition
        expect_at(77,  c_SEL_LED,  8'hFD, "lose_before");
        expect_at(78,  c_SEL_LED,  8'hFB, "lose_led");
        expect_at(78,  c_SEL_BZ,   8'h00, "lose_bz");
        expect_at(90,  c_SEL_SEG1, 8'hF8, "lose_l_frozen");
        expect_at(90,  c_SEL_SEG0, 8'h82, "lose_r_frozen");
        expect_at(90,  c_SEL_BZ,   8'h00, "lose_bz_quiet");
        expect_at(100, c_SEL_LED,  8'hFB, "hold_one_press");
        expect_at(130, c_SEL_LED,  8'hFB, "release_no_press");
        press(72, 50);

        expect_at(140, c_SEL_LED, 8'hFE, "restart2_led");
        press(134, 3);
        expect_at(150, c_SEL_LED, 8'hFD, "stopl3_led");
        press(144, 3);

        // Asynchronous reset while in LSTOP
        expect_at(155, c_SEL_LED,  8'hFE, "midreset_led");
        expect_at(155, c_SEL_SEG0, 8'hC0, "midreset_seg0");
        expect_at(155, c_SEL_SEG1, 8'hC0, "midreset_seg1");
        expect_at(158, c_SEL_LED,  8'hFE, "postreset_led");
        expect_at(158, c_SEL_SEG1, 8'hC0, "postreset_seg1");
        expect_at(158, c_SEL_BZ,   8'h00, "postreset_bz");
        at(155);
        RB = 1'b0;
        at(158);
        RB = 1'b1;

        // First press after reset acts from SPIN; coincides with a tick
        expect_at(169, c_SEL_LED,  8'hFE, "nospurious_press");
        expect_at(170, c_SEL_LED,  8'hFD, "first_press_spin");
        expect_at(171, c_SEL_SEG0, 8'hF8, "tick_r_steps");
        expect_at(175, c_SEL_SEG1, 8'hA4, "tick_l_skipped");
        expect_at(175, c_SEL_SEG0, 8'h82, "r_keeps_spinning");
        press(164, 3);

        at(180);
        #5;
        foreach (q[i]) begin
            n_total++;
            $display("FAIL %s never sampled: got none expected %h", q[i].name, q[i].val);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        if (n_pass == n_total) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule

`default_nettype wire
